// File: rtl/top_tdr_creation_tessent_data_mux_sched_pkg.sv
// Shared types and helpers for the IJTAG data-mux ownership scheduler.
// Holds the scheduler state encoding and the counter sizing rule.
package top_tdr_creation_tessent_data_mux_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUIESCE  = 2'd1,
    ST_OVERRIDE = 2'd2,
    ST_RELEASE  = 2'd3
  } sched_state_t;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/top_tdr_creation_tessent_rr_arbiter.sv
// Combinational rotate-priority pick: the first asserted request at or
// after ptr, wrapping around, wins.
module top_tdr_creation_tessent_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic [IW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      // Candidate at priority offset gi from the pointer.
      assign cand_idx[gi] = (int'(ptr) + gi >= NUM_REQ) ? IW'(int'(ptr) + gi - NUM_REQ)
                                                         : IW'(int'(ptr) + gi);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    // Scanning from the far end lets the smallest offset overwrite last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        valid  = 1'b1;
        winner = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/top_tdr_creation_tessent_data_mux_sched.sv
// Shares one functional/IJTAG data mux among NUM_REQ TDR requesters:
// round-robin grant, quiesce handshake, minimum hold, deselect gap, timeout.
module top_tdr_creation_tessent_data_mux_sched
  import top_tdr_creation_tessent_data_mux_sched_pkg::*;
#(
  parameter int W           = 2,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                 ijtag_tck,
  input  logic                 ijtag_reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] req_data,
  input  logic                 func_idle,
  input  logic                 err_clear,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 func_quiesce_req,
  output logic                 ijtag_select,
  output logic [W-1:0]         ijtag_data_in,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = cnt_width(TIMEOUT);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);

  sched_state_t       state_reg, state_next;
  logic [IW-1:0]      ptr_reg, ptr_next;
  logic [IW-1:0]      owner_reg, owner_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic               quiesce_reg, quiesce_next;
  logic               select_reg, select_next;
  logic [W-1:0]       data_reg, data_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;
  logic               timeout_set;

  logic               arb_valid;
  logic [IW-1:0]      arb_winner;
  logic [W-1:0]       req_data_arr [NUM_REQ];
  logic [W-1:0]       owner_data;
  logic               owner_req;
  logic               hold_done;
  logic               gap_done;

  top_tdr_creation_tessent_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_reg),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_data
      assign req_data_arr[gi] = req_data[gi*W +: W];
    end
  endgenerate

  assign owner_data = req_data_arr[owner_reg];
  assign owner_req  = req[owner_reg];
  // Both counts include the current cycle, hence the +1.
  assign hold_done  = (int'(hold_cnt_reg) + 1 >= HOLD_CYCLES);
  assign gap_done   = (int'(gap_cnt_reg) + 1 >= GAP_CYCLES);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    wait_cnt_next = '0;
    hold_cnt_next = '0;
    gap_cnt_next  = '0;
    grant_next    = grant_reg;
    quiesce_next  = quiesce_reg;
    select_next   = 1'b0;
    data_next     = '0;
    timeout_set   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        grant_next   = '0;
        quiesce_next = 1'b0;
        if (arb_valid) begin
          owner_next   = arb_winner;
          grant_next   = NUM_REQ'(1) << arb_winner;
          quiesce_next = 1'b1;
          ptr_next     = (int'(arb_winner) + 1 >= NUM_REQ) ? '0 : arb_winner + 1'b1;
          state_next   = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        wait_cnt_next = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
        if (!owner_req) begin
          grant_next   = '0;
          quiesce_next = 1'b0;
          state_next   = ST_IDLE;
        end else if (func_idle) begin
          select_next = 1'b1;
          data_next   = owner_data;
          state_next  = ST_OVERRIDE;
        end else if (int'(wait_cnt_reg) >= TIMEOUT) begin
          timeout_set  = 1'b1;
          grant_next   = '0;
          quiesce_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      ST_OVERRIDE: begin
        hold_cnt_next = (hold_cnt_reg == '1) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
        if (!owner_req && hold_done) begin
          state_next = ST_RELEASE;
        end else begin
          select_next = 1'b1;
          data_next   = owner_data;
        end
      end
      ST_RELEASE: begin
        gap_cnt_next = (gap_cnt_reg == '1) ? gap_cnt_reg : gap_cnt_reg + 1'b1;
        if (gap_done) begin
          grant_next   = '0;
          quiesce_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        grant_next   = '0;
        quiesce_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
    // A fresh timeout outranks a simultaneous clear.
    err_next  = timeout_set ? 1'b1 : (err_clear ? 1'b0 : err_reg);
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      wait_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      grant_reg    <= '0;
      quiesce_reg  <= 1'b0;
      select_reg   <= 1'b0;
      data_reg     <= '0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      wait_cnt_reg <= wait_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      grant_reg    <= grant_next;
      quiesce_reg  <= quiesce_next;
      select_reg   <= select_next;
      data_reg     <= data_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
    end
  end

  assign grant            = grant_reg;
  assign func_quiesce_req = quiesce_reg;
  assign ijtag_select     = select_reg;
  assign ijtag_data_in    = data_reg;
  assign busy             = busy_reg;
  assign timeout_err      = err_reg;

endmodule

// File: tb/tb_top_tdr_creation_tessent_data_mux_sched.sv
// Directed bench for the data-mux scheduler with default parameters
// (W=2, NUM_REQ=2, HOLD=4, GAP=2, TIMEOUT=16).
module tb_top_tdr_creation_tessent_data_mux_sched;

  logic       ijtag_tck = 1'b0;
  logic       ijtag_reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] req_data = 4'b0000;
  logic       func_idle = 1'b0;
  logic       err_clear = 1'b0;
  logic [1:0] grant;
  logic       func_quiesce_req;
  logic       ijtag_select;
  logic [1:0] ijtag_data_in;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  logic       sel_seen;
  logic [1:0] rr_exp [3] = '{2'b01, 2'b10, 2'b01};

  top_tdr_creation_tessent_data_mux_sched #(
    .W(2), .NUM_REQ(2), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT(16)
  ) dut (
    .ijtag_tck        (ijtag_tck),
    .ijtag_reset      (ijtag_reset),
    .req              (req),
    .req_data         (req_data),
    .func_idle        (func_idle),
    .err_clear        (err_clear),
    .grant            (grant),
    .func_quiesce_req (func_quiesce_req),
    .ijtag_select     (ijtag_select),
    .ijtag_data_in    (ijtag_data_in),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  task automatic step();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_fqr"}, 32'(func_quiesce_req), 0);
    chk({tag, "_sel"}, 32'(ijtag_select), 0);
    chk({tag, "_data"}, 32'(ijtag_data_in), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    // Reset state
    step(); step();
    ijtag_reset = 1'b0;
    chk_all_zero("rst");

    // Basic override: requester 0, data 2'b10, func_idle two cycles after grant
    req = 2'b01; req_data = 4'b0010;
    step();
    chk("b_grant", 32'(grant), 32'h1);
    chk("b_fqr", 32'(func_quiesce_req), 1);
    chk("b_busy", 32'(busy), 1);
    chk("b_sel_q0", 32'(ijtag_select), 0);
    step();
    chk("b_sel_q1", 32'(ijtag_select), 0);
    func_idle = 1'b1;
    step();
    chk("b_sel_on", 32'(ijtag_select), 1);
    chk("b_data", 32'(ijtag_data_in), 32'h2);
    func_idle = 1'b0;
    step();
    chk("b_sel_ov1", 32'(ijtag_select), 1);
    req = 2'b00;
    step();
    chk("b_sel_ov2", 32'(ijtag_select), 1);
    step();
    chk("b_sel_ov3", 32'(ijtag_select), 1);
    step();
    chk("b_sel_off", 32'(ijtag_select), 0);
    chk("b_data_off", 32'(ijtag_data_in), 0);
    chk("b_fqr_gap0", 32'(func_quiesce_req), 1);
    chk("b_grant_gap0", 32'(grant), 32'h1);
    step();
    chk("b_fqr_gap1", 32'(func_quiesce_req), 1);
    step();
    chk("b_fqr_done", 32'(func_quiesce_req), 0);
    chk("b_grant_done", 32'(grant), 0);
    chk("b_busy_done", 32'(busy), 0);

    // Round-robin from a fresh pointer: 01, 10, 01
    ijtag_reset = 1'b1;
    step();
    ijtag_reset = 1'b0;
    func_idle = 1'b1;
    for (int s = 0; s < 3; s++) begin
      req = 2'b11;
      step();
      chk($sformatf("rr%0d_grant", s), 32'(grant), 32'(rr_exp[s]));
      step();
      chk($sformatf("rr%0d_sel", s), 32'(ijtag_select), 1);
      req = 2'b11 & ~rr_exp[s];
      step(); step(); step();
      chk($sformatf("rr%0d_hold", s), 32'(ijtag_select), 1);
      step();
      chk($sformatf("rr%0d_rel", s), 32'(ijtag_select), 0);
      step(); step();
      chk($sformatf("rr%0d_idle", s), 32'(busy), 0);
      chk($sformatf("rr%0d_gnt0", s), 32'(grant), 0);
    end
    func_idle = 1'b0;
    req = 2'b00;

    // Timeout: requester 1, func_idle held low
    req = 2'b10;
    sel_seen = 1'b0;
    step();
    chk("to_grant", 32'(grant), 32'h2);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (ijtag_select) sel_seen = 1'b1;
    end
    chk("to_err_16", 32'(timeout_err), 0);
    step();
    chk("to_err_17", 32'(timeout_err), 1);
    chk("to_grant0", 32'(grant), 0);
    chk("to_fqr0", 32'(func_quiesce_req), 0);
    chk("to_sel_never", 32'(sel_seen | ijtag_select), 0);
    // Clear while a new grant starts (error does not block grants)
    err_clear = 1'b1;
    step();
    chk("to_clr", 32'(timeout_err), 0);
    chk("to_regrant", 32'(grant), 32'h2);
    err_clear = 1'b0;
    for (int i = 1; i <= 16; i++) step();
    err_clear = 1'b1;
    step();
    chk("to_set_wins", 32'(timeout_err), 1);
    err_clear = 1'b0;
    req = 2'b00;
    step();

    // Abort: requester 1 withdraws as func_idle rises
    req = 2'b10;
    step();
    chk("ab_grant", 32'(grant), 32'h2);
    req = 2'b00; func_idle = 1'b1;
    step();
    chk("ab_grant0", 32'(grant), 0);
    chk("ab_fqr0", 32'(func_quiesce_req), 0);
    chk("ab_sel0", 32'(ijtag_select), 0);
    chk("ab_busy0", 32'(busy), 0);
    func_idle = 1'b0;
    step();
    chk("ab_sel_stay", 32'(ijtag_select), 0);

    // Data tracking with requester 0 as owner
    req = 2'b01;
    step();
    chk("dt_grant", 32'(grant), 32'h1);
    func_idle = 1'b1; req_data = 4'b0000;
    step();
    chk("dt_d00", 32'(ijtag_data_in), 32'h0);
    chk("dt_sel", 32'(ijtag_select), 1);
    func_idle = 1'b0; req_data = 4'b0011;
    step();
    chk("dt_d11", 32'(ijtag_data_in), 32'h3);
    req_data = 4'b0001;
    step();
    chk("dt_d01", 32'(ijtag_data_in), 32'h1);
    req_data = 4'b1001;
    step();
    chk("dt_nonowner", 32'(ijtag_data_in), 32'h1);

    // Reset mid-OVERRIDE; pointer was 1, reset brings it back to 0
    ijtag_reset = 1'b1;
    step();
    ijtag_reset = 1'b0;
    chk_all_zero("mrst");
    req = 2'b11;
    step();
    chk("mrst_grant", 32'(grant), 32'h1);
    req = 2'b00;
    step();
    chk("end_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top_tdr_creation_tessent_data_mux_sched.md
# top_tdr_creation_tessent_data_mux_sched

Scheduler that owns the select and IJTAG-side data of one W-bit functional/IJTAG data mux and shares it among NUM_REQ IJTAG requesters (TDR update paths). It grants ownership round-robin. Before asserting the mux select it performs a quiesce handshake with the functional logic. It enforces a minimum override hold time and a deselect gap, and reports quiesce timeouts. It sits between the TDR registers and the data mux, driving the mux's `ijtag_select` and `ijtag_data_in`.

## Interface
Parameters:
- W, 2, mux data width.
- NUM_REQ, 2, number of requesters, ≥1.
- HOLD_CYCLES, 4, minimum OVERRIDE cycles before release.
- GAP_CYCLES, 2, cycles with select low before quiesce request drops.
- TIMEOUT, 16, QUIESCE cycles allowed without `func_idle`.

Ports:
- `ijtag_tck`  in  1  single clock; all state on rising edge.
- `ijtag_reset`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-requester ownership request (level).
- `req_data`  in  NUM_REQ*W  requester i data at [i*W +: W].
- `func_idle`  in  1  functional logic reports quiesced.
- `err_clear`  in  1  clears `timeout_err`.
- `grant`  out  NUM_REQ  one-hot owner, 0 when unowned.
- `func_quiesce_req`  out  1  request functional logic to quiesce.
- `ijtag_select`  out  1  drives mux select.
- `ijtag_data_in`  out  W  drives mux IJTAG data.
- `busy`  out  1  state ≠ IDLE.
- `timeout_err`  out  1  sticky quiesce-timeout flag.

## Operation
- All outputs are registered. On reset, all outputs are 0, the state is IDLE and the round-robin pointer is 0.
- FSM states: IDLE, QUIESCE, OVERRIDE, RELEASE.
- IDLE:
  - When any `req` bit is high, select the winner as the first set bit at or after the pointer, wrapping.
  - Set `grant` one-hot and set `func_quiesce_req`=1. Set pointer to winner+1 mod NUM_REQ. Go to QUIESCE.
- QUIESCE:
  - A wait counter counts cycles.
  - If `func_idle`=1, go to OVERRIDE.
  - If `req[owner]` drops, abort: go to IDLE and clear `grant` and `func_quiesce_req`. Abort has priority over `func_idle`.
  - If the counter reaches TIMEOUT without `func_idle`, set `timeout_err`, clear `grant` and `func_quiesce_req`, and go to IDLE.
- OVERRIDE:
  - `ijtag_select`=1.
  - `ijtag_data_in` is `req_data[owner]` registered every cycle while `grant`≠0.
  - A hold counter counts OVERRIDE cycles. When `req[owner]`=0 and hold count ≥ HOLD_CYCLES, go to RELEASE.
  - A `func_idle` drop during OVERRIDE is ignored.
- RELEASE:
  - `ijtag_select`=0 and `ijtag_data_in`=0. `func_quiesce_req` stays 1 for GAP_CYCLES cycles, then `grant` and `func_quiesce_req` clear and the FSM goes to IDLE.
  - A new request is evaluated in IDLE only. There is no direct hand-off between owners.
- `timeout_err`: when set and `err_clear` occur in the same cycle, set wins. Otherwise `err_clear` clears the flag. Error does not block later grants.
- Counters are $clog2(max+1) wide, saturate, and are cleared on every state entry.

## Timing
- `req` sampled at edge T in IDLE: `grant` and `func_quiesce_req` are high from T+1.
- `func_idle` sampled high at edge T in QUIESCE: `ijtag_select` is high from T+1, with `ijtag_data_in` already valid in that cycle.
- Data latency in OVERRIDE is 1 cycle from `req_data`.
- `req` drop:
  - Earliest release: `ijtag_select` falls HOLD_CYCLES cycles after OVERRIDE entry.
  - Otherwise `ijtag_select` falls 1 cycle after `req` is sampled low.
- After `ijtag_select` falls, `func_quiesce_req` falls GAP_CYCLES cycles later. The next grant is possible 1 cycle after that.
- Timeout: `timeout_err` is high exactly TIMEOUT+1 cycles after `grant` rises.
- Reset mid-operation: at the next edge all outputs are 0, which restores the functional path immediately.

## Structure
- Shared package `top_tdr_creation_tessent_data_mux_sched_pkg` holds:
  - the state enum (IDLE/QUIESCE/OVERRIDE/RELEASE);
  - the counter-width function.
- One sub-module, `top_tdr_creation_tessent_rr_arbiter`: combinational rotate-priority pick of NUM_REQ requests from the pointer.
- The FSM, counters and output registers live in the top module.
- The existing W-bit data mux is instantiated by the integrator, not inside this block.

## Test plan
- Basic override: `req`=01, `req_data`[1:0]=2'b10, `func_idle` high 2 cycles after grant. Expect `grant`=01, `ijtag_select` rises the cycle after `func_idle`, `ijtag_data_in`=2'b10. Drop `req` after 1 cycle: `ijtag_select` falls after exactly 4 OVERRIDE cycles, and `func_quiesce_req` falls 2 cycles later.
- Round-robin: both `req` high continuously. Expect grants alternate 01, 10, 01 across three sessions, with IDLE between sessions.
- Timeout: `req`=10, `func_idle` held 0. Expect `timeout_err`=1 at 17 cycles after grant, `grant`=0 and `ijtag_select` never high. Then `err_clear`=1 clears it. With `err_clear` coincident with a new timeout, the flag stays 1.
- Abort: `req` withdrawn in QUIESCE, with `func_idle` rising the same cycle. Expect return to IDLE and `ijtag_select` stays 0.
- Data tracking: in OVERRIDE, change `req_data` of the owner 00→11→01. Expect `ijtag_data_in` follows with 1-cycle latency. Changes to the non-owner's data have no effect.
- Reset mid-OVERRIDE: assert `ijtag_reset` for 1 cycle. Expect all outputs 0 at the next edge, and the next grant starts from requester 0.
